// File: rtl/vdp18_vram_arb.sv
// vdp18 VRAM access responder.
// Executes each access slot issued by the timing controller against the VRAM.
// Pattern and sprite fetches are returned on a tagged data port. AC_CPU slots
// service queued host-port read/write requests.
// Build option: define VDP18_CPU_WRBUF_EN to get a 2-entry CPU write FIFO.
// Without it, a single request register holds one CPU request.

package vdp18_arb_pkg;
  typedef enum logic [3:0] {
    AC_NONE = 4'd0,
    AC_PNT  = 4'd1,
    AC_PGT  = 4'd2,
    AC_PCT  = 4'd3,
    AC_STST = 4'd4,
    AC_SATY = 4'd5,
    AC_SATX = 4'd6,
    AC_SATN = 4'd7,
    AC_SATC = 4'd8,
    AC_SPTH = 4'd9,
    AC_SPTL = 4'd10,
    AC_CPU  = 4'd11
  } access_t;
endpackage

module vdp18_vram_arb
  import vdp18_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_5m37_i,
  input  logic              clk_en_acc_i,
  input  access_t           access_type_i,
  input  logic [ADDR_W-1:0] vdp_addr_i,
  input  logic              cpu_rd_req_i,
  input  logic              cpu_wr_req_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic              cpu_busy_o,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic [ADDR_W-1:0] vram_a_o,
  output logic              vram_ce_o,
  output logic              vram_we_o,
  output logic [DATA_W-1:0] vram_d_o,
  input  logic [DATA_W-1:0] vram_d_i,
  output logic [DATA_W-1:0] data_o,
  output access_t           data_type_o,
  output logic              data_vld_o,
  output logic              proto_err_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Slot control decoded from the current state and the slot start strobe.
  logic    start_fetch;
  logic    start_cpu;
  logic    complete;
  logic    abort;
  access_t slot_type;

  // CPU request queue; entry 0 is the head. The plain build never fills entry 1.
  logic [1:0]        q_cnt;
  logic [ADDR_W-1:0] q_addr [2];
  logic [DATA_W-1:0] q_data [2];
  logic              q_wr   [2];
  logic              q_nempty;
  logic              pop;
  logic              push;
  logic              push_idx;
  logic              take_wr;
  logic              take_rd;

  assign q_nempty = (q_cnt != 2'd0);

`ifdef VDP18_CPU_WRBUF_EN
  // Full at two entries; a pending read blocks everything else behind it.
  assign cpu_busy_o = (q_cnt == 2'd2) || (q_nempty && !q_wr[0]);
`else
  // One request at a time.
  assign cpu_busy_o = q_nempty;
`endif

  // Write wins over a simultaneous read; a read only enters an empty queue.
  assign take_wr  = cpu_wr_req_i && !cpu_busy_o;
  assign take_rd  = cpu_rd_req_i && !cpu_wr_req_i && !q_nempty;
  assign push     = take_wr || take_rd;
  assign pop      = complete && (slot_type == AC_CPU);
  // Slot after the surviving entries: 0 if empty or the head leaves now, else 1.
  assign push_idx = q_cnt[0] && !pop;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and slot decisions; a slot start always overrides completion.
  always_comb begin
    state_nxt   = state;
    start_fetch = 1'b0;
    start_cpu   = 1'b0;
    complete    = 1'b0;
    abort       = 1'b0;
    if (clk_en_acc_i) begin
      abort = (state == ST_ACCESS);
      if (access_type_i == AC_CPU) begin
        start_cpu = q_nempty;
      end else if (access_type_i != AC_NONE) begin
        start_fetch = 1'b1;
      end
      state_nxt = (start_fetch || start_cpu) ? ST_ACCESS : ST_IDLE;
    end else if ((state == ST_ACCESS) && clk_en_5m37_i) begin
      complete  = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  // Queue occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q_cnt <= 2'd0;
    end else begin
      q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue storage: shift on pop, then the new request lands behind the survivors.
  always_ff @(posedge clk_i) begin
    if (pop) begin
      q_addr[0] <= q_addr[1];
      q_data[0] <= q_data[1];
      q_wr[0]   <= q_wr[1];
    end
    if (push) begin
      q_addr[push_idx] <= cpu_addr_i;
      q_data[push_idx] <= cpu_data_i;
      q_wr[push_idx]   <= cpu_wr_req_i;
    end
  end

  // VRAM cycle launch/finish and the fetch/CPU return ports.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_type   <= AC_NONE;
      vram_a_o    <= '0;
      vram_ce_o   <= 1'b0;
      vram_we_o   <= 1'b0;
      vram_d_o    <= '0;
      data_o      <= '0;
      data_type_o <= AC_NONE;
      data_vld_o  <= 1'b0;
      cpu_data_o  <= '0;
      cpu_ack_o   <= 1'b0;
      proto_err_o <= 1'b0;
    end else begin
      data_vld_o <= 1'b0;
      cpu_ack_o  <= 1'b0;
      if (abort) begin
        proto_err_o <= 1'b1;
      end
      if (start_fetch) begin
        slot_type <= access_type_i;
        vram_a_o  <= vdp_addr_i;
        vram_ce_o <= 1'b1;
        vram_we_o <= 1'b0;
      end else if (start_cpu) begin
        slot_type <= AC_CPU;
        vram_a_o  <= q_addr[0];
        vram_ce_o <= 1'b1;
        vram_we_o <= q_wr[0];
        vram_d_o  <= q_data[0];
      end else if (clk_en_acc_i || complete) begin
        vram_ce_o <= 1'b0;
        vram_we_o <= 1'b0;
      end
      if (complete) begin
        if (slot_type == AC_CPU) begin
          cpu_ack_o <= 1'b1;
          if (!vram_we_o) begin
            cpu_data_o <= vram_d_i;
          end
        end else begin
          data_o      <= vram_d_i;
          data_type_o <= slot_type;
          data_vld_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vdp18_vram_arb.sv
// Bench for vdp18_vram_arb: directed slot scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_vdp18_vram_arb;
  import vdp18_arb_pkg::*;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en5 = 1'b0;
  logic              acc = 1'b0;
  access_t           acc_type = AC_NONE;
  logic [ADDR_W-1:0] vdp_addr = '0;
  logic              rd_req = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_busy;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] vram_a;
  logic              vram_ce;
  logic              vram_we;
  logic [DATA_W-1:0] vram_dout;
  logic [DATA_W-1:0] vram_din;
  logic [DATA_W-1:0] data;
  access_t           data_type;
  logic              data_vld;
  logic              proto_err;

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  assign vram_din = mem[vram_a];

  always #5 clk = ~clk;

  vdp18_vram_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .reset_i(reset), .clk_en_5m37_i(en5), .clk_en_acc_i(acc),
    .access_type_i(acc_type), .vdp_addr_i(vdp_addr),
    .cpu_rd_req_i(rd_req), .cpu_wr_req_i(wr_req), .cpu_addr_i(cpu_addr),
    .cpu_data_i(cpu_wdata), .cpu_busy_o(cpu_busy), .cpu_ack_o(cpu_ack),
    .cpu_data_o(cpu_rdata), .vram_a_o(vram_a), .vram_ce_o(vram_ce),
    .vram_we_o(vram_we), .vram_d_o(vram_dout), .vram_d_i(vram_din),
    .data_o(data), .data_type_o(data_type), .data_vld_o(data_vld),
    .proto_err_o(proto_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending requests as a queue, plus one in-flight slot record.
  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              q[$];
  bit                fl_valid;
  bit                fl_wr;
  access_t           fl_type;
  logic [ADDR_W-1:0] fl_addr;
  logic [ADDR_W-1:0] e_a;
  logic              e_ce, e_we, e_vld, e_ack, e_perr;
  logic [DATA_W-1:0] e_vd, e_data, e_cdata;
  access_t           e_type;

  function automatic bit model_busy();
`ifdef VDP18_CPU_WRBUF_EN
    return (q.size() >= 2) || (q.size() > 0 && !q[0].wr);
`else
    return q.size() > 0;
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    fl_valid = 0; fl_wr = 0; fl_type = AC_NONE; fl_addr = '0;
    e_a = '0; e_ce = 0; e_we = 0; e_vld = 0; e_ack = 0; e_perr = 0;
    e_vd = '0; e_data = '0; e_cdata = '0; e_type = AC_NONE;
  endtask

  task automatic model_step(input bit en, input bit a, input access_t typ,
                            input logic [ADDR_W-1:0] vaddr, input bit rd, input bit wr,
                            input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cdata);
    bit   take_wr, take_rd;
    req_t r;
    take_wr = wr && !model_busy();
    take_rd = rd && !wr && (q.size() == 0);
    e_vld = 0;
    e_ack = 0;
    if (a) begin
      if (fl_valid) e_perr = 1;
      fl_valid = 0;
      if (typ != AC_NONE && typ != AC_CPU) begin
        fl_valid = 1; fl_type = typ; fl_addr = vaddr; fl_wr = 0;
        e_a = vaddr; e_ce = 1; e_we = 0;
      end else if (typ == AC_CPU && q.size() > 0) begin
        fl_valid = 1; fl_type = AC_CPU; fl_addr = q[0].addr; fl_wr = q[0].wr;
        e_a = q[0].addr; e_ce = 1; e_we = q[0].wr; e_vd = q[0].data;
      end else begin
        e_ce = 0; e_we = 0;
      end
    end else if (en && fl_valid) begin
      fl_valid = 0; e_ce = 0; e_we = 0;
      if (fl_type == AC_CPU) begin
        e_ack = 1;
        if (!fl_wr) e_cdata = mem[fl_addr];
        void'(q.pop_front());
      end else begin
        e_data = mem[fl_addr]; e_type = fl_type; e_vld = 1;
      end
    end
    if (take_wr || take_rd) begin
      r.wr = take_wr; r.addr = caddr; r.data = cdata;
      q.push_back(r);
    end
  endtask

  task automatic check_all();
    check_eq("ce", 32'(vram_ce), 32'(e_ce));
    check_eq("we", 32'(vram_we), 32'(e_we));
    check_eq("vram_a", 32'(vram_a), 32'(e_a));
    check_eq("vram_d", 32'(vram_dout), 32'(e_vd));
    check_eq("vld", 32'(data_vld), 32'(e_vld));
    check_eq("ack", 32'(cpu_ack), 32'(e_ack));
    check_eq("busy", 32'(cpu_busy), 32'(model_busy()));
    check_eq("perr", 32'(proto_err), 32'(e_perr));
    check_eq("data", 32'(data), 32'(e_data));
    check_eq("dtype", 32'(data_type), 32'(e_type));
    check_eq("cpu_data", 32'(cpu_rdata), 32'(e_cdata));
  endtask

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit en, input bit a, input access_t typ,
                     input logic [ADDR_W-1:0] vaddr, input bit rd, input bit wr,
                     input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cdata);
    en5 = en; acc = a; acc_type = typ; vdp_addr = vaddr;
    rd_req = rd; wr_req = wr; cpu_addr = caddr; cpu_wdata = cdata;
    model_step(en, a, typ, vaddr, rd, wr, caddr, cdata);
    @(posedge clk);
    #1;
    check_all();
    if (cpu_ack) ack_seen++;
  endtask

  task automatic slot(input access_t typ, input logic [ADDR_W-1:0] vaddr);
    cyc(1, 1, typ, vaddr, 0, 0, '0, '0);
  endtask

  task automatic px();
    cyc(1, 0, AC_NONE, '0, 0, 0, '0, '0);
  endtask

  task automatic req(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] d);
    cyc(0, 0, AC_NONE, '0, rd, wr, addr, d);
  endtask

  task automatic set_idle();
    en5 = 0; acc = 0; acc_type = AC_NONE; vdp_addr = '0;
    rd_req = 0; wr_req = 0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
    mem[14'h1800] = 8'h5A;
    mem[14'h3FFF] = 8'h3C;
    model_reset();

    // Power-up reset
    do_reset();

    // Reset asserted mid-access with a request pending
    req(0, 1, 14'h0010, 8'h77);
    slot(AC_PNT, 14'h0100);
    check_eq("t1_pre_ce", 32'(vram_ce), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t1_ce", 32'(vram_ce), 32'd0);
    check_eq("t1_we", 32'(vram_we), 32'd0);
    check_eq("t1_vld", 32'(data_vld), 32'd0);
    check_eq("t1_ack", 32'(cpu_ack), 32'd0);
    check_eq("t1_busy", 32'(cpu_busy), 32'd0);
    set_idle();
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all();

    // Pattern-name fetch
    slot(AC_PNT, 14'h1800);
    check_eq("t2_a", 32'(vram_a), 32'h1800);
    check_eq("t2_ce", 32'(vram_ce), 32'd1);
    cyc(0, 0, AC_NONE, '0, 0, 0, '0, '0);
    cyc(0, 0, AC_NONE, '0, 0, 0, '0, '0);
    px();
    check_eq("t2_data", 32'(data), 32'h5A);
    check_eq("t2_type", 32'(data_type), 32'(AC_PNT));
    check_eq("t2_vld", 32'(data_vld), 32'd1);
    cyc(0, 0, AC_NONE, '0, 0, 0, '0, '0);
    check_eq("t2_vld_pulse", 32'(data_vld), 32'd0);

    // CPU write, with a fetch slot in between
    do_reset();
    req(0, 1, 14'h0123, 8'hA5);
    slot(AC_PGT, 14'h0200);
    check_eq("t3_fetch_we", 32'(vram_we), 32'd0);
    px();
    slot(AC_CPU, '0);
    check_eq("t3_we", 32'(vram_we), 32'd1);
    check_eq("t3_d", 32'(vram_dout), 32'hA5);
    check_eq("t3_a", 32'(vram_a), 32'h0123);
    px();
    check_eq("t3_ack", 32'(cpu_ack), 32'd1);

    // CPU read at the top address, then an AC_CPU slot with nothing queued
    do_reset();
    req(1, 0, 14'h3FFF, 8'h00);
    slot(AC_CPU, '0);
    check_eq("t4_a", 32'(vram_a), 32'h3FFF);
    px();
    check_eq("t4_ack", 32'(cpu_ack), 32'd1);
    check_eq("t4_rdata", 32'(cpu_rdata), 32'h3C);
    slot(AC_CPU, '0);
    check_eq("t4_empty_ce", 32'(vram_ce), 32'd0);
    px();

    // Request on a slot-start edge, then a second write while the first is pending
    do_reset();
    ack_seen = 0;
    cyc(1, 1, AC_CPU, '0, 0, 1, 14'h0042, 8'h11);
    check_eq("t5_same_edge_ce", 32'(vram_ce), 32'd0);
    req(0, 1, 14'h0043, 8'h22);
    slot(AC_CPU, '0);
    check_eq("t5_a", 32'(vram_a), 32'h0042);
    px();
    slot(AC_CPU, '0);
    px();
`ifdef VDP18_CPU_WRBUF_EN
    check_eq("t5_acks", 32'(ack_seen), 32'd2);
`else
    check_eq("t5_acks", 32'(ack_seen), 32'd1);
`endif

    // Slot start during an access in flight
    do_reset();
    slot(AC_PNT, 14'h1000);
    slot(AC_PGT, 14'h1001);
    check_eq("t6_perr", 32'(proto_err), 32'd1);
    check_eq("t6_a", 32'(vram_a), 32'h1001);
    px();
    check_eq("t6_type", 32'(data_type), 32'(AC_PGT));

`ifdef VDP18_CPU_WRBUF_EN
    // Write FIFO depth and read blocking
    do_reset();
    ack_seen = 0;
    req(0, 1, 14'h0001, 8'h01);
    req(0, 1, 14'h0002, 8'h02);
    check_eq("t6_full", 32'(cpu_busy), 32'd1);
    req(0, 1, 14'h0003, 8'h03);
    req(1, 0, 14'h0004, 8'h00);
    slot(AC_CPU, '0); px();
    slot(AC_CPU, '0); px();
    slot(AC_CPU, '0);
    check_eq("t6_drained_ce", 32'(vram_ce), 32'd0);
    check_eq("t6_wr_acks", 32'(ack_seen), 32'd2);
    req(1, 0, 14'h1800, 8'h00);
    check_eq("t6_rd_busy", 32'(cpu_busy), 32'd1);
    slot(AC_CPU, '0); px();
    check_eq("t6_rdata", 32'(cpu_rdata), 32'h5A);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit      en_r, acc_r, rd_r, wr_r;
      access_t t_r;
      en_r  = ($urandom % 3) == 0;
      acc_r = en_r && (($urandom % 2) == 0);
      t_r   = access_t'($urandom_range(0, 11));
      rd_r  = ($urandom % 6) == 0;
      wr_r  = ($urandom % 6) == 0;
      cyc(en_r, acc_r, t_r, 14'($urandom), rd_r, wr_r, 14'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
